// File: rtl/lsu_ctrl.sv
// Load/store controller: word-aligned memory accesses, read-modify-write for sub-word stores.
// Define LSU_ERR_CHECK_EN to report misaligned, out-of-range and illegal-funct3 requests.
module lsu_ctrl #(
  parameter int unsigned DM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  // DM_BYTES is a power of two; the memory decodes the low AW address bits
  localparam int unsigned AW = $clog2(DM_BYTES);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state, state_n;
  logic        we_q, we_n;
  size_t       size_q, size_n;
  logic        uns_q, uns_n;
  logic [1:0]  lane_q, lane_n;
  logic [31:0] waddr_q, waddr_n;
  logic [31:0] wdata_q, wdata_n;

  logic        resp_valid_n, resp_err_n;
  logic [31:0] resp_rdata_n, mem_address_n, mem_write_data_n;
  logic        mem_we_n, mem_re_n;

  size_t       dec_size;
  logic        dec_uns, dec_ill, dec_err;
  logic [1:0]  dec_lane;
  logic [31:0] dec_waddr;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign req_ready = (state == IDLE);

  // Lane-shift the read word and extend to 32 bits
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input size_t size, input logic uns);
    logic [31:0] w;
    w = word >> {lane, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      SZ_H:    return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Replace the addressed byte/halfword of the read word with store data
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input size_t size);
    logic [31:0] mask;
    logic [31:0] data;
    mask = ((size == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
    data = wdata << {lane, 3'b000};
    return (word & ~mask) | (data & mask);
  endfunction

  // Request decode: access size, signedness, lane and word address
  always_comb begin
    dec_size = SZ_W;
    dec_uns  = 1'b0;
    dec_ill  = 1'b0;
    case (req_funct3)
      3'b000:  dec_size = SZ_B;
      3'b001:  dec_size = SZ_H;
      3'b010:  dec_size = SZ_W;
      3'b100: begin
        dec_size = SZ_B;
        dec_uns  = 1'b1;
        dec_ill  = req_we;
      end
      3'b101: begin
        dec_size = SZ_H;
        dec_uns  = 1'b1;
        dec_ill  = req_we;
      end
      default: dec_ill = 1'b1;
    endcase
`ifdef LSU_ERR_CHECK_EN
    dec_err   = dec_ill
              || ((dec_size == SZ_H) && req_addr[0])
              || ((dec_size == SZ_W) && (req_addr[1:0] != 2'b00))
              || (req_addr >= 32'(DM_BYTES));
    dec_lane  = req_addr[1:0];
    dec_waddr = {req_addr[31:2], 2'b00};
`else
    dec_err = 1'b0;
    if (dec_ill) begin
      dec_size = SZ_W;
      dec_uns  = 1'b0;
    end
    dec_lane = req_addr[1:0];
    if (((dec_size == SZ_H) && req_addr[0]) || (dec_size == SZ_W)) begin
      dec_lane = 2'd0;
    end
    dec_waddr = 32'({req_addr[AW-1:2], 2'b00});
`endif
  end

  // Next state, captured request and next registered outputs
  always_comb begin
    state_n          = state;
    we_n             = we_q;
    size_n           = size_q;
    uns_n            = uns_q;
    lane_n           = lane_q;
    waddr_n          = waddr_q;
    wdata_n          = wdata_q;
    resp_valid_n     = 1'b0;
    resp_rdata_n     = 32'd0;
    resp_err_n       = 1'b0;
    mem_address_n    = 32'd0;
    mem_write_data_n = 32'd0;
    mem_we_n         = 1'b0;
    mem_re_n         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          we_n    = req_we;
          size_n  = dec_size;
          uns_n   = dec_uns;
          lane_n  = dec_lane;
          waddr_n = dec_waddr;
          wdata_n = req_wdata;
          if (dec_err) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else if (req_we && (dec_size == SZ_W)) begin
            state_n          = WRITE;
            mem_we_n         = 1'b1;
            mem_address_n    = dec_waddr;
            mem_write_data_n = req_wdata;
          end else begin
            state_n       = READ;
            mem_re_n      = 1'b1;
            mem_address_n = dec_waddr;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_n          = WRITE;
          mem_we_n         = 1'b1;
          mem_address_n    = waddr_q;
          mem_write_data_n = store_merge(mem_read_data, wdata_q, lane_q, size_q);
        end else begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = load_ext(mem_read_data, lane_q, size_q, uns_q);
        end
      end
      WRITE: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      we_q             <= 1'b0;
      size_q           <= SZ_B;
      uns_q            <= 1'b0;
      lane_q           <= 2'd0;
      waddr_q          <= 32'd0;
      wdata_q          <= 32'd0;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'd0;
      resp_err         <= 1'b0;
      mem_address      <= 32'd0;
      mem_write_data   <= 32'd0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      state            <= state_n;
      we_q             <= we_n;
      size_q           <= size_n;
      uns_q            <= uns_n;
      lane_q           <= lane_n;
      waddr_q          <= waddr_n;
      wdata_q          <= wdata_n;
      resp_valid       <= resp_valid_n;
      resp_rdata       <= resp_rdata_n;
      resp_err         <= resp_err_n;
      mem_address      <= mem_address_n;
      mem_write_data   <= mem_write_data_n;
      mem_write_enable <= mem_we_n;
      mem_read_enable  <= mem_re_n;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array reference model predicts the per-cycle bus and response schedule.
module tb_lsu_ctrl;
  localparam int unsigned DM = 128;
  localparam int unsigned NW = DM / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  always #5 clk = ~clk;

  lsu_ctrl #(.DM_BYTES(DM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data)
  );

  // Data memory seen by the DUT
  logic [31:0] env_mem [NW];
  assign mem_read_data = env_mem[mem_address[6:2]];
  always @(posedge clk) if (mem_write_enable) env_mem[mem_address[6:2]] <= mem_write_data;

  // Expected outputs for one cycle of an in-flight request
  typedef struct packed {
    logic        rd, wr, rsp, err;
    logic [31:0] addr, wdata, rdata;
  } cyc_t;

  cyc_t       sched[$];
  logic [7:0] rmem [DM];
  int errors = 0, checks = 0;
  int n_accept = 0, n_abort = 0, n_resp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    env_mem[w] = v;
    for (int i = 0; i < 4; i++) rmem[4*w+i] = v[8*i +: 8];
  endtask

  // Build the cycle schedule of an accepted request from the architectural rules
  function automatic void model_accept(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd);
    int size, lane, base;
    bit uns, ill, err;
    logic [31:0] ea, val, w;
    cyc_t c;
    size = 4; uns = 0; ill = 0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; ill = we; end
      3'd5: begin size = 2; uns = 1; ill = we; end
      default: ill = 1;
    endcase
`ifdef LSU_ERR_CHECK_EN
    err  = ill || (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00) || (a >= DM);
    ea   = a;
    lane = int'(a[1:0]);
`else
    err = 0;
    if (ill) begin size = 4; uns = 0; end
    ea   = a % DM;
    lane = int'(ea % 4);
    if (lane % size != 0) lane = 0;
`endif
    c = '0;
    if (err) begin
      c.rsp = 1; c.err = 1;
      sched.push_back(c);
      return;
    end
    base = int'(ea) - int'(ea % 4);
    if (!we) begin
      val = '0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = rmem[base+lane+i];
      if (!uns && size < 4 && val[8*size-1])
        for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
      c.rd = 1; c.addr = 32'(base);
      sched.push_back(c);
      c = '0; c.rsp = 1; c.rdata = val;
      sched.push_back(c);
    end else begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = rmem[base+i];
      for (int i = 0; i < size; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      if (size < 4) begin
        c.rd = 1; c.addr = 32'(base);
        sched.push_back(c);
      end
      c = '0; c.wr = 1; c.addr = 32'(base); c.wdata = w;
      sched.push_back(c);
      c = '0; c.rsp = 1;
      sched.push_back(c);
    end
  endfunction

  // Model advance: a write commits only when its cycle completes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (sched.size() != 0) n_abort++;
      sched.delete();
    end else if (sched.size() != 0) begin
      if (sched[0].wr)
        for (int i = 0; i < 4; i++) rmem[sched[0].addr + 32'(i)] = sched[0].wdata[8*i +: 8];
      void'(sched.pop_front());
    end else if (req_valid) begin
      n_accept++;
      model_accept(req_we, req_funct3, req_addr, req_wdata);
    end
  end

  // Per-cycle compare against the model schedule
  always @(negedge clk) begin : cmp
    cyc_t e;
    logic exp_rdy;
    e = '0;
    exp_rdy = 1'b1;
    if (rst_n && sched.size() != 0) begin
      e = sched[0];
      exp_rdy = 1'b0;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mem_read_enable", 32'(mem_read_enable), 32'(e.rd));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(e.wr));
    chk("resp_valid", 32'(resp_valid), 32'(e.rsp));
    if (e.rd || e.wr) chk("mem_address", mem_address, e.addr);
    if (e.wr) chk("mem_write_data", mem_write_data, e.wdata);
    if (e.rsp) begin
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", 32'(resp_err), 32'(e.err));
    end
    if (rst_n && resp_valid) n_resp++;
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold,
                        output logic [31:0] rd, output logic er, output int lat);
    bit ok, got;
    #1;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    rd = '0; er = 1'b0; lat = 0; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    lat = 1; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin rd = resp_rdata; er = resp_err; got = 1; end
      @(posedge clk);
      lat++;
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};

    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int w = 0; w < NW; w++) set_word(w, $urandom());
    set_word(2, 32'h1122_3344);
    set_word(3, 32'h80FF_7F01);
    set_word(4, 32'hCAFE_F00D);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    #2 rst_n = 1'b1;

    do_req(1'b1, 3'd2, 32'h4, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_mem", env_mem[1], 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h4, 32'h0, 1'b0, rd, er, lat);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    do_req(1'b1, 3'd0, 32'h9, 32'h0000_00AB, 1'b0, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_mem", env_mem[2], 32'h1122_AB44);
    do_req(1'b0, 3'd0, 32'hE, 32'h0, 1'b0, rd, er, lat);
    chk("lb_data", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 3'd4, 32'hE, 32'h0, 1'b0, rd, er, lat);
    chk("lbu_data", rd, 32'h0000_00FF);
    do_req(1'b0, 3'd1, 32'hE, 32'h0, 1'b0, rd, er, lat);
    chk("lh_data", rd, 32'hFFFF_80FF);
    do_req(1'b0, 3'd5, 32'hC, 32'h0, 1'b0, rd, er, lat);
    chk("lhu_data", rd, 32'h0000_7F01);
`ifdef LSU_ERR_CHECK_EN
    do_req(1'b0, 3'd2, 32'h6, 32'h0, 1'b0, rd, er, lat);
    chk("lw6_err", 32'(er), 32'd1);
    chk("lw6_lat", 32'(lat), 32'd2);
    chk("lw6_rdata", rd, 32'd0);
    do_req(1'b1, 3'd1, 32'h3, 32'h1234, 1'b0, rd, er, lat);
    chk("sh3_err", 32'(er), 32'd1);
    chk("sh3_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'd2, 32'h80, 32'h0, 1'b0, rd, er, lat);
    chk("lw80_err", 32'(er), 32'd1);
    chk("lw80_lat", 32'(lat), 32'd2);
`else
    do_req(1'b0, 3'd2, 32'h6, 32'h0, 1'b0, rd, er, lat);
    chk("lw6_data", rd, 32'hDEAD_BEEF);
    chk("lw6_err", 32'(er), 32'd0);
    chk("lw6_lat", 32'(lat), 32'd3);
`endif

    // Reset during the WRITE cycle of an SB must leave memory untouched
    #1;
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h5A; req_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_write", 32'(mem_write_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_drop", 32'(mem_write_enable), 32'd0);
    chk("abort_ready_rst", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("abort_mem", env_mem[4], 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      logic we, hold;
      logic [2:0] f3;
      logic [31:0] a;
      we   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom());
      else if (we) f3 = st_f3[$urandom_range(0, 2)];
      else f3 = ld_f3[$urandom_range(0, 4)];
      a = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, DM - 1));
      do_req(we, f3, a, $urandom(), hold, rd, er, lat);
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);

    chk("resp_count", 32'(n_resp), 32'(n_accept - n_abort));
    for (int w = 0; w < NW; w++)
      chk("final_mem", env_mem[w], {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
